// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants, twiddle table, bit-reverse helper and FSM
//               encoding for the iterative NTT controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int N     = 9;    // coefficient width, Q < 2^N
  localparam int D     = 8;    // transform length, power of two, >= 4
  localparam int Q     = 257;  // prime modulus, D divides Q-1
  localparam int OMEGA = 4;    // primitive D-th root of unity mod Q
  localparam int LOG2D = $clog2(D);
  localparam int SW    = $clog2(LOG2D);  // stage counter width

  typedef logic [N-1:0] coef_t;
  typedef coef_t tw_tab_t [D/2];

  // OMEGA^m mod Q for m = 0..D/2-1, evaluated at elaboration time
  function automatic tw_tab_t gen_tw();
    tw_tab_t t;
    longint  p;
    p = 1;
    for (int m = 0; m < D/2; m++) begin
      t[m] = coef_t'(p);
      p    = (p * OMEGA) % Q;
    end
    return t;
  endfunction

  localparam tw_tab_t TW = gen_tw();

  // Reverse the LOG2D-bit index so the DIT network produces natural-order output
  function automatic logic [LOG2D-1:0] bitrev(input logic [LOG2D-1:0] x);
    logic [LOG2D-1:0] r;
    for (int b = 0; b < LOG2D; b++) r[b] = x[LOG2D-1-b];
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : ntt_butterfly
// Description : Combinational radix-2 modular butterfly:
//               o_sum = (a + w*b) mod Q, o_diff = (a - w*b) mod Q.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_butterfly
  import ntt_pkg::*;
(
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_w,
  output logic [N-1:0] o_sum,
  output logic [N-1:0] o_diff
);

  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_t;
  logic [N:0]     w_s;

  // Full-width product, one reduction, then conditional-subtract add/sub
  always_comb begin
    w_prod = {{N{1'b0}}, i_w} * {{N{1'b0}}, i_b};
    w_t    = coef_t'(w_prod % (2*N)'(Q));
    w_s    = {1'b0, i_a} + {1'b0, w_t};
    o_sum  = (w_s >= (N+1)'(Q)) ? coef_t'(w_s - (N+1)'(Q)) : coef_t'(w_s);
    o_diff = (i_a >= w_t) ? (i_a - w_t)
                          : coef_t'({1'b0, i_a} + (N+1)'(Q) - {1'b0, w_t});
  end

endmodule
`default_nettype wire

// File: rtl/ntt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ntt_seq_ctrl
// Description : Iterative D-point NTT. Loads D coefficients in bit-reversed
//               order, runs log2(D) DIT stages through one shared butterfly,
//               then streams D results out in natural order.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_seq_ctrl
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  state_t           r_state;
  logic [LOG2D-1:0] r_cnt;     // load / unload index
  logic [SW-1:0]    r_stage;   // DIT stage s
  logic [LOG2D-2:0] r_bfly;    // butterfly counter c within a stage
  coef_t            r_bank [D];

  logic [LOG2D-1:0] w_h, w_k, w_i, w_j, w_c;
  logic [LOG2D-2:0] w_m;
  coef_t            w_in_red, w_sum, w_diff;
  logic             w_acc_in, w_acc_out;

  // Butterfly addressing and input reduction
  always_comb begin
    w_c       = {1'b0, r_bfly};
    w_h       = LOG2D'(1) << r_stage;
    w_k       = w_c & (w_h - LOG2D'(1));
    w_i       = (((w_c >> r_stage) << r_stage) << 1) | w_k;
    w_j       = w_i | w_h;
    w_m       = (LOG2D-1)'(w_k << (LOG2D - 1 - int'(r_stage)));
    w_in_red  = (in_data >= N'(Q)) ? (in_data - N'(Q)) : in_data;
    w_acc_in  = in_valid && in_ready;
    w_acc_out = out_valid && out_ready;
  end

  ntt_butterfly u_bfly (
    .i_a   (r_bank[w_i]),
    .i_b   (r_bank[w_j]),
    .i_w   (TW[w_m]),
    .o_sum (w_sum),
    .o_diff(w_diff)
  );

  // Register bank: bit-reversed load, in-place butterfly write-back
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && w_acc_in) begin
      r_bank[bitrev(r_cnt)] <= w_in_red;
    end else if (r_state == S_COMPUTE) begin
      r_bank[w_i] <= w_sum;
      r_bank[w_j] <= w_diff;
    end
  end

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_stage   <= '0;
      r_bfly    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_acc_in) begin
            if (r_cnt == LOG2D'(D-1)) begin
              r_cnt    <= '0;
              r_state  <= S_COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (r_bfly == {(LOG2D-1){1'b1}}) begin
            r_bfly <= '0;
            if (r_stage == SW'(LOG2D-1)) begin
              r_stage   <= '0;
              r_state   <= S_UNLOAD;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              // The final butterfly writes bank[D/2-1] and bank[D-1], so
              // bank[0] already holds X[0] here.
              out_data  <= r_bank[0];
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end else begin
            r_bfly <= r_bfly + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (w_acc_out) begin
            if (r_cnt == LOG2D'(D-1)) begin
              r_cnt     <= '0;
              r_state   <= S_LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              out_data  <= '0;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              out_data <= r_bank[r_cnt + 1'b1];
              out_last <= ((r_cnt + 1'b1) == LOG2D'(D-1));
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire
